// File: rtl/asym_fifo_wide2narrow.sv
`default_nettype none
// ============================================================================
// Module   : asym_fifo_wide2narrow
// Function : Single-clock stream FIFO, W_WR-bit words in, W_RD-bit beats out
//            with packet-last flag and first-word-fall-through output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module asym_fifo_wide2narrow #(
  parameter int W_WR      = 16,
  parameter int W_RD      = 4,
  parameter int DEPTH_RD  = 1024,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [W_WR-1:0]               s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [W_RD-1:0]               m_data,
  output logic                          m_last,
  output logic [$clog2(DEPTH_RD+3)-1:0] count,
  output logic                          empty
);

  localparam int c_RATIO = W_WR / W_RD;
  localparam int c_WORDS = DEPTH_RD / c_RATIO;
  localparam int c_WP_W  = $clog2(c_WORDS);
  localparam int c_RP_W  = $clog2(DEPTH_RD);
  localparam int c_RC_W  = $clog2(DEPTH_RD + 1);
  localparam int c_CNT_W = $clog2(DEPTH_RD + 3);

  generate
    if (W_WR % W_RD != 0) begin : g_errWidth
      $error("asym_fifo_wide2narrow: W_WR must be an integer multiple of W_RD");
    end
    if ((DEPTH_RD & (DEPTH_RD - 1)) != 0) begin : g_errDepth
      $error("asym_fifo_wide2narrow: DEPTH_RD must be a power of 2");
    end
    if ((c_RATIO & (c_RATIO - 1)) != 0) begin : g_errRatio
      $error("asym_fifo_wide2narrow: W_WR/W_RD must be a power of 2");
    end
    if (DEPTH_RD < 2 * c_RATIO) begin : g_errSmall
      $error("asym_fifo_wide2narrow: DEPTH_RD must be at least 2*W_WR/W_RD");
    end
  endgenerate

  logic [W_RD-1:0]    r_mem     [DEPTH_RD];
  logic               r_lastMem [c_WORDS];
  logic [W_RD-1:0]    w_slice   [c_RATIO];
  logic [c_WP_W-1:0]  r_wrPtr;
  logic [c_RP_W-1:0]  r_rdPtr;
  logic [c_RC_W-1:0]  r_ramCnt;
  logic [c_RC_W-1:0]  w_ramCntNext;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_countNext;
  logic               r_alive;
  logic               r_rdVld;
  logic [W_RD-1:0]    r_rdData;
  logic               r_rdLast;
  logic [W_RD-1:0]    r_bufData [2];
  logic               r_bufLast [2];
  logic [1:0]         r_bufCnt;
  logic [1:0]         w_bufKeep;
  logic [1:0]         w_bufNext;
  logic               w_wrEn;
  logic               w_pop;
  logic               w_fetch;
  logic               w_rdLastSlice;

  generate
    for (genvar gi = 0; gi < c_RATIO; gi++) begin : g_slice
      assign w_slice[gi] = MSB_FIRST ? s_data[(c_RATIO-1-gi)*W_RD +: W_RD]
                                     : s_data[gi*W_RD +: W_RD];
    end
  endgenerate

  assign s_ready = r_alive && (r_ramCnt <= c_RC_W'(DEPTH_RD - c_RATIO));
  assign w_wrEn  = s_valid && s_ready;
  assign m_valid = (r_bufCnt != 2'd0);
  assign w_pop   = m_valid && m_ready;
  assign m_data  = r_bufData[0];
  assign m_last  = r_bufLast[0];
  assign count   = r_count;
  assign empty   = (r_count == '0);

  // Occupancy the buffer will have after this edge; a fetch is allowed only
  // while that plus the beat it launches stays within the two entries.
  assign w_bufKeep = r_bufCnt - {1'b0, w_pop};
  assign w_bufNext = w_bufKeep + {1'b0, r_rdVld};
  assign w_fetch   = (r_ramCnt != '0) && (w_bufNext < 2'd2);

  assign w_rdLastSlice = ((int'(r_rdPtr) % c_RATIO) == (c_RATIO - 1));

  always_comb begin
    w_ramCntNext = r_ramCnt;
    w_countNext  = r_count;
    if (w_wrEn) begin
      w_ramCntNext = w_ramCntNext + c_RC_W'(c_RATIO);
      w_countNext  = w_countNext + c_CNT_W'(c_RATIO);
    end
    if (w_fetch) w_ramCntNext = w_ramCntNext - c_RC_W'(1);
    if (w_pop)   w_countNext  = w_countNext - c_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < c_RATIO; i++) begin
        r_mem[c_RP_W'(int'(r_wrPtr) * c_RATIO + i)] <= w_slice[i];
      end
      r_lastMem[r_wrPtr] <= s_last;
    end
    if (w_fetch) begin
      r_rdData <= r_mem[r_rdPtr];
      r_rdLast <= r_lastMem[r_rdPtr[c_RP_W-1 -: c_WP_W]] && w_rdLastSlice;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alive  <= 1'b0;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_ramCnt <= '0;
      r_count  <= '0;
      r_rdVld  <= 1'b0;
      r_bufCnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_bufData[i] <= '0;
        r_bufLast[i] <= 1'b0;
      end
    end else begin
      r_alive  <= 1'b1;
      r_ramCnt <= w_ramCntNext;
      r_count  <= w_countNext;
      r_rdVld  <= w_fetch;
      r_bufCnt <= w_bufNext;
      if (w_wrEn)  r_wrPtr <= r_wrPtr + c_WP_W'(1);
      if (w_fetch) r_rdPtr <= r_rdPtr + c_RP_W'(1);
      // Head only shifts when a second entry exists, so an emptied buffer keeps its last beat.
      if (w_pop && (r_bufCnt == 2'd2)) begin
        r_bufData[0] <= r_bufData[1];
        r_bufLast[0] <= r_bufLast[1];
      end
      if (r_rdVld) begin
        r_bufData[w_bufKeep[0]] <= r_rdData;
        r_bufLast[w_bufKeep[0]] <= r_rdLast;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asym_fifo_wide2narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_asym_fifo_wide2narrow
// Function : Directed and scoreboarded checks of asym_fifo_wide2narrow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asym_fifo_wide2narrow;

  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid, m_last, empty;
  logic [3:0]  m_data;
  logic [10:0] count;
  logic        s_ready1, m_valid1, m_last1, empty1;
  logic [3:0]  m_data1;
  logic [10:0] count1;

  asym_fifo_wide2narrow #(.W_WR(16), .W_RD(4), .DEPTH_RD(1024), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .count(count), .empty(empty));

  asym_fifo_wide2narrow #(.W_WR(16), .W_RD(4), .DEPTH_RD(1024), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .count(count1), .empty(empty1));

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference stream model: handshakes sampled half a cycle before the edge that takes them.
  logic [4:0] sbQ [$];
  logic [4:0] sbExp;
  bit         sbOn = 1'b0;
  int         wordsIn = 0;

  always @(negedge clk) begin
    if (sbOn && rstn) begin
      if (m_valid && m_ready) begin
        if (sbQ.size() == 0) begin
          check("sb_spurious_beat", {31'b0, m_valid}, 32'd0);
        end else begin
          sbExp = sbQ.pop_front();
          check("sb_data", {28'b0, m_data}, {28'b0, sbExp[3:0]});
          check("sb_last", {31'b0, m_last}, {31'b0, sbExp[4]});
        end
      end
      if (s_valid && s_ready) begin
        wordsIn++;
        for (int i = 0; i < RATIO; i++) begin
          sbQ.push_back({(i == RATIO - 1) && s_last, s_data[i*4 +: 4]});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] ordLsb [4];
  logic [3:0] ordMsb [4];
  int         acc, cyc, beat, gaps, startWords;
  bit         willAcc;

  initial begin
    ordLsb = '{4'h5, 4'hC, 4'h3, 4'hA};
    ordMsb = '{4'hA, 4'h3, 4'hC, 4'h5};

    // Reset state
    tick(3);
    rstn = 1'b1;
    tick(1);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_count",   count,   0);
    check("rst_empty",   empty,   1);
    check("rst_m_data",  m_data,  0);
    check("rst_m_last",  m_last,  0);

    // Slice order and latency
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'hA3C5; s_last = 1'b0;
    tick(1);
    s_valid = 1'b0;
    check("ord_count_t",   count,   4);
    check("ord_mvalid_t",  m_valid, 0);
    tick(1);
    check("ord_mvalid_t1", m_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("ord_mvalid", m_valid, 1);
      check("ord_lsb",    m_data,  ordLsb[k]);
      check("ord_msb",    m_data1, ordMsb[k]);
      check("ord_mlast",  m_last,  0);
    end
    tick(1);
    check("ord_drained_valid", m_valid, 0);
    check("ord_drained_empty", empty,   1);
    check("ord_hold_lsb",      m_data,  4'hA);
    check("ord_hold_msb",      m_data1, 4'h5);

    // Packet-last flag across two words
    s_valid = 1'b1; s_data = 16'h3210; s_last = 1'b0;
    tick(1);
    s_data = 16'h7654; s_last = 1'b1;
    tick(1);
    s_valid = 1'b0; s_last = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 8 && cyc < 40) begin
      if (m_valid) begin
        check("last_data", m_data, beat);
        check("last_flag", m_last, (beat == 7) ? 1 : 0);
        beat++;
      end
      tick(1);
      cyc++;
    end
    check("last_beats", beat, 8);

    // Output stall holds head, count moves only on handshakes
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'hD1B2; s_last = 1'b1;
    tick(1);
    s_valid = 1'b0; s_last = 1'b0;
    tick(3);
    check("stall_first", m_data, 4'h2);
    check("stall_count4", count, 4);
    m_ready = 1'b1;
    tick(3);
    m_ready = 1'b0;
    check("stall_head", m_data, 4'hD);
    check("stall_count1", count, 1);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("stall_data",  m_data,  4'hD);
      check("stall_last",  m_last,  1);
      check("stall_valid", m_valid, 1);
      check("stall_count", count,   1);
    end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("stall_done_count", count,   0);
    check("stall_done_valid", m_valid, 0);
    check("stall_done_hold",  m_data,  4'hD);

    // Fill to capacity with the output blocked
    sbOn = 1'b1;
    acc = 0; cyc = 0;
    s_valid = 1'b1;
    while (acc < 256 && cyc < 600) begin
      s_data = 16'($urandom);
      s_last = 1'($urandom_range(0, 1));
      willAcc = s_ready;
      tick(1);
      if (willAcc) acc++;
      cyc++;
    end
    check("fill_words",   acc,     256);
    check("fill_s_ready", s_ready, 0);
    check("fill_count",   count,   1024);
    tick(5);
    check("fill_no_extra", count, 1024);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(2);
    check("fill_drain1_ready", s_ready, 0);
    check("fill_drain1_count", count,   1023);
    m_ready = 1'b1;
    tick(3);
    m_ready = 1'b0;
    tick(2);
    check("fill_drain4_ready", s_ready, 1);
    check("fill_drain4_count", count,   1020);
    m_ready = 1'b1;
    cyc = 0;
    while (!empty && cyc < 2000) begin tick(1); cyc++; end
    check("fill_empty", empty, 1);
    check("fill_sb_left", sbQ.size(), 0);

    // Gap-free stream with both sides always ready
    s_valid = 1'b1;
    s_data = 16'($urandom);
    cyc = 0;
    while (!m_valid && cyc < 10) begin
      tick(1);
      s_data = 16'($urandom);
      cyc++;
    end
    check("tput_first_beat", m_valid, 1);
    gaps = 0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      s_data = 16'($urandom);
      if (!m_valid) gaps++;
    end
    check("tput_gaps", gaps, 0);
    s_valid = 1'b0;
    cyc = 0;
    while (!empty && cyc < 2000) begin tick(1); cyc++; end
    check("tput_empty", empty, 1);

    // Random traffic across many pointer wraps
    startWords = wordsIn;
    cyc = 0;
    while ((wordsIn - startWords) < 3000 && cyc < 40000) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 16'($urandom);
      s_last  = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 9) < 7);
      tick(1);
      cyc++;
    end
    check("rand_words_done", ((wordsIn - startWords) >= 3000) ? 1 : 0, 1);
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (!empty && cyc < 2000) begin tick(1); cyc++; end
    check("rand_empty",   empty,      1);
    check("rand_count",   count,      0);
    check("rand_sb_left", sbQ.size(), 0);
    sbOn = 1'b0;

    // Reset asserted mid-transfer
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'h5A5A; s_last = 1'b1;
    tick(3);
    s_valid = 1'b0; s_last = 1'b0;
    tick(3);
    check("mid_pre_valid", m_valid, 1);
    rstn = 1'b0;
    #1;
    check("mid_m_valid", m_valid, 0);
    check("mid_count",   count,   0);
    check("mid_empty",   empty,   1);
    check("mid_m_data",  m_data,  0);
    check("mid_m_last",  m_last,  0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    check("mid_rel_ready", s_ready, 1);
    check("mid_rel_valid", m_valid, 0);
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h1234;
    tick(1);
    s_valid = 1'b0;
    tick(2);
    check("mid_fresh_beat",  m_data, 4'h4);
    check("mid_fresh_count", count,  4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
